// File: rtl/fp_special_cases_pipe_pkg.sv
// Shared definitions for the special-operand resolver pipeline.
//   fp_type_e : operand class codes produced by fp_classify
//   op_e      : operation codes carried on the op port
//   DEF_*     : default field widths (IEEE-754 binary32)
package fp_special_cases_pipe_pkg;

  localparam int DEF_EXP_SIZE    = 8;
  localparam int DEF_MANTIS_SIZE = 23;

  typedef enum logic [2:0] {
    FP_ZERO      = 3'b000,
    FP_INF       = 3'b001,
    FP_SUBNORMAL = 3'b010,
    FP_NORMAL    = 3'b011,
    FP_NAN       = 3'b100
  } fp_type_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

endpackage

// File: rtl/fp_special_cases_pipe_if.sv
// Operand/result handshake bundle for fp_special_cases_pipe.
//   in_valid/in_ready   : operand beat handshake (op, opnd_a, opnd_b)
//   out_valid/out_ready : result beat handshake (result, special_case, invalid)
//   master : producer/consumer side; slave : the resolver pipeline
interface fp_special_cases_pipe_if
  import fp_special_cases_pipe_pkg::*;
#(
  parameter int EXP_SIZE    = DEF_EXP_SIZE,
  parameter int MANTIS_SIZE = DEF_MANTIS_SIZE
);
  localparam int W = 1 + EXP_SIZE + MANTIS_SIZE;

  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] opnd_a;
  logic [W-1:0] opnd_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         special_case;
  logic         invalid;

  modport master (
    output in_valid, op, opnd_a, opnd_b, out_ready,
    input  in_ready, out_valid, result, special_case, invalid
  );

  modport slave (
    input  in_valid, op, opnd_a, opnd_b, out_ready,
    output in_ready, out_valid, result, special_case, invalid
  );

endinterface

// File: rtl/fp_special_cases_pipe_classify.sv
// fp_classify: combinational operand classifier.
//   mag     in  {exp, mantis} fields of an operand (sign is irrelevant here)
//   ftype   out ZERO / SUBNORMAL / NORMAL / INF / NAN
//   is_snan out NaN whose quiet bit (mantissa MSB) is clear
module fp_classify
  import fp_special_cases_pipe_pkg::*;
#(
  parameter int EXP_SIZE    = DEF_EXP_SIZE,
  parameter int MANTIS_SIZE = DEF_MANTIS_SIZE
) (
  input  logic [EXP_SIZE+MANTIS_SIZE-1:0] mag,
  output fp_type_e                        ftype,
  output logic                            is_snan
);

  logic [EXP_SIZE-1:0]    exp_f;
  logic [MANTIS_SIZE-1:0] man_f;

  assign exp_f = mag[EXP_SIZE+MANTIS_SIZE-1:MANTIS_SIZE];
  assign man_f = mag[MANTIS_SIZE-1:0];

  always_comb begin
    ftype   = FP_NORMAL;
    is_snan = 1'b0;
    if (exp_f == '0) begin
      ftype = (man_f == '0) ? FP_ZERO : FP_SUBNORMAL;
    end else if (&exp_f) begin
      if (man_f == '0) begin
        ftype = FP_INF;
      end else begin
        ftype   = FP_NAN;
        is_snan = ~man_f[MANTIS_SIZE-1];
      end
    end
  end

endmodule

// File: rtl/fp_special_cases_pipe.sv
// fp_special_cases_pipe: two-stage special-operand resolver for ADD/SUB/MUL.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of fp_special_cases_pipe_if
//     S1 holds op, operands (SUB already folded into sign_B) and operand classes.
//     S2 holds result, special_case and invalid; result is zero when not special.
module fp_special_cases_pipe
  import fp_special_cases_pipe_pkg::*;
#(
  parameter int EXP_SIZE    = DEF_EXP_SIZE,
  parameter int MANTIS_SIZE = DEF_MANTIS_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_special_cases_pipe_if.slave bus
);

  localparam int W = 1 + EXP_SIZE + MANTIS_SIZE;
  // Canonical quiet NaN and the quiet-bit mask used to quiet propagated NaNs.
  localparam logic [W-1:0] CQ    = {1'b1, {EXP_SIZE{1'b1}}, 1'b1, {(MANTIS_SIZE-1){1'b0}}};
  localparam logic [W-1:0] QMASK = {1'b0, {EXP_SIZE{1'b0}}, 1'b1, {(MANTIS_SIZE-1){1'b0}}};
  localparam logic [W-1:0] INF_MAG = {1'b0, {EXP_SIZE{1'b1}}, {MANTIS_SIZE{1'b0}}};

  // ---------------- handshake ----------------
  logic s1_valid_reg, s2_valid_reg;
  logic s2_load, s1_load;

  // A stage may load when its output is empty or leaving this cycle.
  assign s2_load      = ~s2_valid_reg | bus.out_ready;
  assign s1_load      = ~s1_valid_reg | s2_load;
  assign bus.in_ready = s1_load;

  // ---------------- stage 1 ----------------
  fp_type_e type_a, type_b;
  logic     snan_a, snan_b;

  fp_classify #(.EXP_SIZE(EXP_SIZE), .MANTIS_SIZE(MANTIS_SIZE)) u_class_a (
    .mag     (bus.opnd_a[W-2:0]),
    .ftype   (type_a),
    .is_snan (snan_a)
  );

  fp_classify #(.EXP_SIZE(EXP_SIZE), .MANTIS_SIZE(MANTIS_SIZE)) u_class_b (
    .mag     (bus.opnd_b[W-2:0]),
    .ftype   (type_b),
    .is_snan (snan_b)
  );

  op_e          s1_op_reg;
  logic [W-1:0] s1_a_reg, s1_b_reg;
  fp_type_e     s1_ta_reg, s1_tb_reg;
  logic         s1_snan_a_reg, s1_snan_b_reg;
  logic [W-1:0] opnd_b_next;

  // Subtraction is addition with B's sign flipped; later logic only sees ADD/MUL.
  assign opnd_b_next = (op_e'(bus.op) == OP_SUB) ? {~bus.opnd_b[W-1], bus.opnd_b[W-2:0]}
                                                  : bus.opnd_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_op_reg     <= OP_ADD;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_ta_reg     <= FP_ZERO;
      s1_tb_reg     <= FP_ZERO;
      s1_snan_a_reg <= 1'b0;
      s1_snan_b_reg <= 1'b0;
    end else if (s1_load) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op_reg     <= op_e'(bus.op);
        s1_a_reg      <= bus.opnd_a;
        s1_b_reg      <= opnd_b_next;
        s1_ta_reg     <= type_a;
        s1_tb_reg     <= type_b;
        s1_snan_a_reg <= snan_a;
        s1_snan_b_reg <= snan_b;
      end
    end
  end

  // ---------------- resolver (feeds stage 2) ----------------
  logic [W-1:0] res_next;
  logic         special_next, invalid_next;
  logic         sa, sb, smul, is_mul;
  logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [MANTIS_SIZE-1:0] man_a, man_b;

  assign sa     = s1_a_reg[W-1];
  assign sb     = s1_b_reg[W-1];
  assign smul   = sa ^ sb;
  assign man_a  = s1_a_reg[MANTIS_SIZE-1:0];
  assign man_b  = s1_b_reg[MANTIS_SIZE-1:0];
  assign is_mul = (s1_op_reg == OP_MUL);
  assign a_nan  = (s1_ta_reg == FP_NAN);
  assign b_nan  = (s1_tb_reg == FP_NAN);
  assign a_inf  = (s1_ta_reg == FP_INF);
  assign b_inf  = (s1_tb_reg == FP_INF);
  assign a_zero = (s1_ta_reg == FP_ZERO);
  assign b_zero = (s1_tb_reg == FP_ZERO);

  always_comb begin
    res_next     = '0;
    special_next = 1'b0;
    invalid_next = 1'b0;
    if (a_nan || b_nan) begin
      // NaN handling is identical for every op.
      special_next = 1'b1;
      invalid_next = s1_snan_a_reg | s1_snan_b_reg;
      if (a_nan && b_nan) begin
        res_next = ((man_b > man_a) ? s1_b_reg : s1_a_reg) | QMASK;
        if (man_a == man_b) res_next[W-1] = sa & sb;
      end else if (a_nan) begin
        res_next = s1_a_reg | QMASK;
      end else begin
        res_next = s1_b_reg | QMASK;
      end
    end else if (is_mul) begin
      if ((a_zero && b_inf) || (a_inf && b_zero)) begin
        special_next = 1'b1;
        invalid_next = 1'b1;
        res_next     = CQ;
      end else if (a_inf || b_inf) begin
        special_next = 1'b1;
        res_next     = INF_MAG | {smul, {(W-1){1'b0}}};
      end else if (a_zero || b_zero) begin
        special_next = 1'b1;
        res_next     = {smul, {(W-1){1'b0}}};
      end
    end else begin
      if (a_zero && b_zero) begin
        special_next = 1'b1;
        res_next     = {sa & sb, {(W-1){1'b0}}};
      end else if (a_zero) begin
        special_next = 1'b1;
        res_next     = s1_b_reg;
      end else if (b_zero) begin
        special_next = 1'b1;
        res_next     = s1_a_reg;
      end else if (a_inf && b_inf) begin
        special_next = 1'b1;
        if (sa == sb) begin
          res_next = s1_a_reg;
        end else begin
          res_next     = CQ;
          invalid_next = 1'b1;
        end
      end else if (a_inf) begin
        special_next = 1'b1;
        res_next     = s1_a_reg;
      end else if (b_inf) begin
        special_next = 1'b1;
        res_next     = s1_b_reg;
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [W-1:0] result_reg;
  logic         special_reg, invalid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      result_reg   <= '0;
      special_reg  <= 1'b0;
      invalid_reg  <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg  <= res_next;
        special_reg <= special_next;
        invalid_reg <= invalid_next;
      end
    end
  end

  assign bus.out_valid    = s2_valid_reg;
  assign bus.result       = result_reg;
  assign bus.special_case = special_reg;
  assign bus.invalid      = invalid_reg;

endmodule

// File: tb/tb_fp_special_cases_pipe.sv
// Testbench for fp_special_cases_pipe (binary32): directed vector table,
// backpressure ordering sequence and mid-flight reset sequence.
module tb_fp_special_cases_pipe;

  logic clk;
  logic rst_n;

  fp_special_cases_pipe_if #(.EXP_SIZE(8), .MANTIS_SIZE(23)) bus ();

  fp_special_cases_pipe #(.EXP_SIZE(8), .MANTIS_SIZE(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        sp;
    logic        inv;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    int cyc;
    bus.op       = vecs[idx].op;
    bus.opnd_a   = vecs[idx].a;
    bus.opnd_b   = vecs[idx].b;
    bus.in_valid = 1'b1;
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("vec%0d out_valid", idx), {31'd0, bus.out_valid}, 32'd1);
    check($sformatf("vec%0d latency", idx), cyc, 32'd2);
    check($sformatf("vec%0d result", idx), bus.result, vecs[idx].res);
    check($sformatf("vec%0d special", idx), {31'd0, bus.special_case}, {31'd0, vecs[idx].sp});
    check($sformatf("vec%0d invalid", idx), {31'd0, bus.invalid}, {31'd0, vecs[idx].inv});
    $display("vec%0d op=%0d a=%08h b=%08h -> res=%08h sp=%0b inv=%0b", idx, vecs[idx].op,
             vecs[idx].a, vecs[idx].b, bus.result, bus.special_case, bus.invalid);
  endtask

  initial begin
    logic [31:0] bp_exp [8];
    int          sent, got, cyc;
    logic        fire_in, fire_out, stalled, seen;
    logic [31:0] held;

    vecs[0]  = '{2'b00, 32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b1, 1'b1};
    vecs[1]  = '{2'b10, 32'h00000000, 32'hFF800000, 32'hFFC00000, 1'b1, 1'b1};
    vecs[2]  = '{2'b10, 32'h80000000, 32'h3F800000, 32'h80000000, 1'b1, 1'b0};
    vecs[3]  = '{2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00001, 1'b1, 1'b1};
    vecs[4]  = '{2'b00, 32'h7FC00002, 32'hFFC00005, 32'hFFC00005, 1'b1, 1'b0};
    vecs[5]  = '{2'b01, 32'h80000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 32'h7F800000, 32'h7F800000, 32'hFFC00000, 1'b1, 1'b1};
    vecs[8]  = '{2'b00, 32'h7F800000, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0};
    vecs[9]  = '{2'b00, 32'h00000000, 32'hC0400000, 32'hC0400000, 1'b1, 1'b0};
    vecs[10] = '{2'b01, 32'h00000000, 32'h3F800000, 32'hBF800000, 1'b1, 1'b0};
    vecs[11] = '{2'b10, 32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1, 1'b0};
    vecs[12] = '{2'b10, 32'h7F800000, 32'h00000001, 32'h7F800000, 1'b1, 1'b0};
    vecs[13] = '{2'b10, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
    vecs[14] = '{2'b10, 32'h00400000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[15] = '{2'b00, 32'h00000001, 32'h00000000, 32'h00000001, 1'b1, 1'b0};
    vecs[16] = '{2'b00, 32'h80000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[17] = '{2'b11, 32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b1, 1'b1};
    vecs[18] = '{2'b00, 32'h7F800003, 32'hFF800003, 32'h7FC00003, 1'b1, 1'b1};
    vecs[19] = '{2'b10, 32'h3F800000, 32'hFF800005, 32'hFFC00005, 1'b1, 1'b1};
    vecs[20] = '{2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0};
    vecs[21] = '{2'b01, 32'h3F800000, 32'hFFC00001, 32'h7FC00001, 1'b1, 1'b0};
    vecs[22] = '{2'b00, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0};
    vecs[23] = '{2'b10, 32'hFF800000, 32'h80000000, 32'hFFC00000, 1'b1, 1'b1};

    // ---- reset state ----
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.opnd_a    = '0;
    bus.opnd_b    = '0;
    bus.out_ready = 1'b1;
    #12;
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset result", bus.result, 32'd0);
    check("reset special", {31'd0, bus.special_case}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed table ----
    for (int i = 0; i < NVEC; i++) run_vec(i);
    @(posedge clk); #1;

    // ---- backpressure: 8 back-to-back beats, random out_ready ----
    for (int i = 0; i < 8; i++) bp_exp[i] = 32'h3F800000 + i;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    bus.op = 2'b00; bus.opnd_a = 32'h0; bus.opnd_b = bp_exp[0]; bus.in_valid = 1'b1;
    while (got < 8 && cyc < 300) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      fire_in  = bus.in_valid & bus.in_ready;
      fire_out = bus.out_valid & bus.out_ready;
      if (stalled && bus.out_valid) check($sformatf("bp stall hold %0d", got), bus.result, held);
      if (fire_out) begin
        check($sformatf("bp beat%0d result", got), bus.result, bp_exp[got]);
        check($sformatf("bp beat%0d special", got), {31'd0, bus.special_case}, 32'd1);
        $display("bp beat%0d delivered res=%08h at cycle %0d", got, bus.result, cyc);
        got++;
      end
      stalled = bus.out_valid & ~bus.out_ready;
      held    = bus.result;
      @(posedge clk); #1;
      cyc++;
      if (fire_in) begin
        sent++;
        if (sent < 8) bus.opnd_b = bp_exp[sent];
        else bus.in_valid = 1'b0;
      end
    end
    check("bp beats delivered", got, 32'd8);
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= bus.out_valid;
    end
    check("bp no extra beat", {31'd0, seen}, 32'd0);

    // ---- reset with two beats in flight ----
    bus.out_ready = 1'b0;
    bus.op = 2'b00; bus.opnd_a = 32'h7F800000; bus.opnd_b = 32'h3F800000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.opnd_a = 32'h7F800001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("inflight out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("inflight in_ready", {31'd0, bus.in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midreset in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= bus.out_valid;
    end
    check("post-reset no beat", {31'd0, seen}, 32'd0);
    check("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    $display("reset sequence done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
